// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port: funct3 size codes,
// FSM state encoding and the size-to-byte-mask helper.
package lsu_pkg;

  localparam logic [1:0] LSU_B = 2'b00;
  localparam logic [1:0] LSU_H = 2'b01;
  localparam logic [1:0] LSU_W = 2'b10;
  localparam logic [1:0] LSU_D = 2'b11;

  // funct3 bit selecting zero-extension on loads
  localparam int unsigned LSU_UNSIGNED_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      LSU_B:   return 8'h01;
      LSU_H:   return 8'h03;
      LSU_W:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte strobes, store-data replication and
// load-lane extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned NB    = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(NB)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  rdata,
  output logic [NB-1:0]    wstrb,
  output logic [XLEN-1:0]  wdata_rep,
  output logic [XLEN-1:0]  rdata_ext
);

  logic [15:0]     mask_wide;
  logic [XLEN-1:0] shifted;
  int unsigned     lane_bits;
  int unsigned     msb;
  logic            ext_bit;

  always_comb begin
    mask_wide = {8'h00, size_mask(funct3[1:0])} << offset;
    wstrb     = mask_wide[NB-1:0];
  end

  // Lane width may exceed XLEN for an (illegal) double on a 32-bit port;
  // clamp so the sign bit index stays in range.
  always_comb begin
    lane_bits = 32'd8 << funct3[1:0];
    msb       = ((lane_bits < XLEN) ? lane_bits : XLEN) - 1;
    shifted   = rdata >> {offset, 3'b000};
    ext_bit   = ~funct3[LSU_UNSIGNED_BIT] & shifted[msb];
    wdata_rep = '0;
    rdata_ext = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      wdata_rep[i] = wdata[i % lane_bits];
      rdata_ext[i] = (i <= msb) ? shifted[i] : ext_bit;
    end
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-request load/store port to the memory bus with size decode,
// alignment checking and lane steering. Optional LSU_TIMEOUT_EN aborts
// an ACCESS that sees no mem_response within TIMEOUT_CYCLES.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_response,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  lsu_state_e       state, next_state;
  logic [2:0]       lat_funct3;
  logic             lat_write;
  logic [OFF_W-1:0] lat_off;
  logic [XLEN-1:0]  lat_wdata;

  logic             accept;
  logic             req_illegal;
  logic             req_misaligned;
  logic             req_bad;
  logic [2:0]       align_mask;
  logic             timeout;

  logic [NB-1:0]    align_wstrb;
  logic [XLEN-1:0]  align_wdata;
  logic [XLEN-1:0]  align_rdata;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign req_ready = (state == ST_IDLE) && resetn;
  assign rsp_valid = (state == ST_RESP);

  always_comb begin
    case (req_funct3[1:0])
      LSU_B:   align_mask = 3'b000;
      LSU_H:   align_mask = 3'b001;
      LSU_W:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    req_misaligned = |(req_addr[2:0] & align_mask);
    req_illegal    = ((req_funct3[1:0] == LSU_D) && (XLEN == 32))
                   || (req_write && req_funct3[LSU_UNSIGNED_BIT])
                   || (!req_write && (XLEN == 32) && (req_funct3 == 3'b110));
    req_bad        = req_illegal || req_misaligned;
  end

`ifdef LSU_TIMEOUT_EN
  logic [31:0] wait_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == ST_ACCESS) && !mem_response) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // A response arriving on the timeout edge takes priority.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state == ST_ACCESS) && !mem_response
                && (wait_cnt == TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = req_bad ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_response || timeout) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_funct3  <= '0;
      lat_write   <= 1'b0;
      lat_off     <= '0;
      lat_wdata   <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else if (accept) begin
      lat_funct3  <= req_funct3;
      lat_write   <= req_write;
      lat_off     <= req_addr[OFF_W-1:0];
      lat_wdata   <= req_wdata;
      mem_address <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      mem_read    <= !req_bad && !req_write;
      mem_write   <= !req_bad && req_write;
      rsp_rdata   <= '0;
      rsp_err     <= req_bad;
    end else if (state == ST_ACCESS) begin
      if (mem_response) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        rsp_rdata <= lat_write ? '0 : align_rdata;
        rsp_err   <= 1'b0;
      end else if (timeout) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

  lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
    .funct3    (lat_funct3),
    .offset    (lat_off),
    .wdata     (lat_wdata),
    .rdata     (mem_rdata),
    .wstrb     (align_wstrb),
    .wdata_rep (align_wdata),
    .rdata_ext (align_rdata)
  );

  // Lanes are driven only while a store is on the bus.
  assign mem_wstrb = mem_write ? align_wstrb : '0;
  assign mem_wdata = mem_write ? align_wdata : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port (XLEN = 32).
module tb_lsu_mem_port;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_response = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_port #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_response (mem_response),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; mem_response is raised in the ACCESS cycle numbered 'delay'.
  task automatic run_access(input string tag, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int delay,
                            input logic exp_err, input logic [3:0] exp_wstrb,
                            input logic [31:0] exp_mwdata, input logic [31:0] exp_addr,
                            input logic [31:0] exp_rdata);
    check_eq({tag, ".ready_in"}, 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    if (!exp_err) begin
      for (int c = 0; c <= delay; c++) begin
        check_eq({tag, ".mem_read"},  64'(mem_read),    64'(!wr));
        check_eq({tag, ".mem_write"}, 64'(mem_write),   64'(wr));
        check_eq({tag, ".addr"},      64'(mem_address), 64'(exp_addr));
        check_eq({tag, ".wstrb"},     64'(mem_wstrb),   64'(exp_wstrb));
        check_eq({tag, ".wdata"},     64'(mem_wdata),   64'(exp_mwdata));
        check_eq({tag, ".busy"},      64'({req_ready, rsp_valid}), 64'd0);
        if (c == delay) begin
          mem_rdata    = rdata;
          mem_response = 1'b1;
        end
        tick();
        mem_response = 1'b0;
        mem_rdata    = 32'h5A5A_5A5A;
      end
    end
    check_eq({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    check_eq({tag, ".rsp_err"},   64'(rsp_err),   64'(exp_err));
    check_eq({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check_eq({tag, ".strobes_off"}, 64'({mem_read, mem_write}), 64'd0);
    tick();
    check_eq({tag, ".rsp_pulse"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, ".ready_out"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_eq("rst.ready",   64'(req_ready), 64'd0);
    check_eq("rst.strobes", 64'({mem_read, mem_write, mem_wstrb}), 64'd0);
    check_eq("rst.rsp",     64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    check_eq("rst.addr",    64'(mem_address), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    check_eq("rst.ready_after", 64'(req_ready), 64'd1);

    //          tag     wr  f3      addr          wdata         rdata        dly err wstrb    mwdata        maddr         rdata_exp
    run_access("sw",    1, 3'b010, 32'h100,      32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h100,      32'h0);
    run_access("lb",    0, 3'b000, 32'h203,      32'h0,        32'h80FFFFFF, 0, 0, 4'b0000, 32'h0,        32'h200,      32'hFFFFFF80);
    run_access("lbu",   0, 3'b100, 32'h203,      32'h0,        32'h80FFFFFF, 0, 0, 4'b0000, 32'h0,        32'h200,      32'h00000080);
    run_access("sh",    1, 3'b001, 32'h0A,       32'h1234,     32'h0,        0, 0, 4'b1100, 32'h12341234, 32'h08,       32'h0);
    run_access("lw_mis",0, 3'b010, 32'h0A,       32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        32'h0);
    run_access("lw_d5", 0, 3'b010, 32'h100,      32'h0,        32'hCAFEF00D, 5, 0, 4'b0000, 32'h0,        32'h100,      32'hCAFEF00D);
    run_access("sb_b2b",1, 3'b000, 32'h01,       32'h7F,       32'h0,        0, 0, 4'b0010, 32'h7F7F7F7F, 32'h0,        32'h0);
    run_access("lh",    0, 3'b001, 32'h1002,     32'h0,        32'h80010000, 1, 0, 4'b0000, 32'h0,        32'h1000,     32'hFFFF8001);
    run_access("lhu",   0, 3'b101, 32'h06,       32'h0,        32'h80010000, 0, 0, 4'b0000, 32'h0,        32'h04,       32'h00008001);
    run_access("sb_hi", 1, 3'b000, 32'hFFFFFF03, 32'h123456A5, 32'h0,        2, 0, 4'b1000, 32'hA5A5A5A5, 32'hFFFFFF00, 32'h0);
    run_access("sd_ill",1, 3'b011, 32'h0,        32'h1,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        32'h0);
    run_access("sbu_ill",1,3'b100, 32'h0,        32'h1,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        32'h0);
    run_access("lwu_ill",0,3'b110, 32'h0,        32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        32'h0);
    run_access("lh_mis",0, 3'b001, 32'h03,       32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        32'h0);
    run_access("sw_mis",1, 3'b010, 32'h102,      32'h1,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0,        32'h0);

    // Stray bus response while idle
    mem_response = 1'b1;
    tick();
    mem_response = 1'b0;
    check_eq("idle_rsp.valid", 64'(rsp_valid), 64'd0);
    check_eq("idle_rsp.ready", 64'(req_ready), 64'd1);

    // Reset while an access is outstanding
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    tick();
    req_valid = 1'b0;
    check_eq("rst_acc.read", 64'(mem_read), 64'd1);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_acc.strobes", 64'({mem_read, mem_write}), 64'd0);
    check_eq("rst_acc.rsp",     64'({rsp_valid, rsp_err}), 64'd0);
    check_eq("rst_acc.ready",   64'(req_ready), 64'd0);
    tick();
    resetn = 1'b1;
    #1;
    check_eq("rst_acc.ready_rel", 64'(req_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("rst_acc.no_rsp", 64'({rsp_valid, mem_read}), 64'd0);
    end

`ifdef LSU_TIMEOUT_EN
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h80;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_eq("tmo.read", 64'(mem_read), 64'd1);
      check_eq("tmo.wait", 64'(rsp_valid), 64'd0);
      tick();
    end
    check_eq("tmo.read_drop", 64'(mem_read), 64'd0);
    check_eq("tmo.rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("tmo.rsp_err",   64'(rsp_err), 64'd1);
    check_eq("tmo.rsp_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    check_eq("tmo.ready", 64'(req_ready), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
